// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the scoreboarded register file: geometry and the
// hardwired zero-register address.
package reg_file_sb_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_SIZE   = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, reserve acceptance and a registered pending count.
// rsv_ok_o is combinational; busy bits and the count update on the next clk edge. No backpressure.
module reg_file_sb_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [SIZE-1:0]       wa_i,
    input  logic                  rsv_i,
    input  logic [SIZE-1:0]       rsv_addr_i,
    output logic                  rsv_ok_o,
    output logic [(1<<SIZE)-1:0]  busy_o,
    output logic [SIZE:0]         pending_cnt_o
);

    localparam int              NREG      = 1 << SIZE;
    localparam logic [SIZE-1:0] ZERO_ADDR = SIZE'(ZERO_REG);
    localparam logic [SIZE:0]   CNT_ONE   = {{SIZE{1'b0}}, 1'b1};

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [SIZE:0]   cnt_q;
    logic [SIZE:0]   cnt_d;
    logic            wr_nz;
    logic            rsv_set;
    logic            cnt_inc;
    logic            cnt_dec;

    assign wr_nz    = we_i && (wa_i != ZERO_ADDR);
    // A write landing in the same cycle frees the slot, so the reserve may chain onto it.
    assign rsv_ok_o = rsv_i && ((rsv_addr_i == ZERO_ADDR) || !busy_q[rsv_addr_i] ||
                                (we_i && (wa_i == rsv_addr_i)));
    assign rsv_set  = rsv_ok_o && (rsv_addr_i != ZERO_ADDR);

    always_comb begin
        busy_d = busy_q;
        if (wr_nz)
            busy_d[wa_i] = 1'b0;
        if (rsv_set)
            busy_d[rsv_addr_i] = 1'b1;
        busy_d[0] = 1'b0;

        // A clear that is immediately re-reserved leaves the bit set: no decrement.
        cnt_inc = rsv_set && !busy_q[rsv_addr_i];
        cnt_dec = wr_nz && busy_q[wa_i] && !(rsv_set && (rsv_addr_i == wa_i));

        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec)
            cnt_d = cnt_q + CNT_ONE;
        else if (cnt_dec && !cnt_inc)
            cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with hardwired r0, NUM_RD combinational read ports and a pending-write scoreboard.
// Reads zero latency, writes visible next cycle (same cycle via bypass when REG_FILE_SB_BYPASS_EN is defined); no backpressure.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SIZE   = DEF_SIZE,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we_i,
    input  logic [SIZE-1:0]         wa_i,
    input  logic [WIDTH-1:0]        wd_i,
    input  logic                    rsv_i,
    input  logic [SIZE-1:0]         rsv_addr_i,
    output logic                    rsv_ok_o,
    input  logic [NUM_RD*SIZE-1:0]  rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]       rd_busy_o,
    output logic [SIZE:0]           pending_cnt_o
);

    localparam int              NREG      = 1 << SIZE;
    localparam logic [SIZE-1:0] ZERO_ADDR = SIZE'(ZERO_REG);

    logic [WIDTH-1:0] mem_q [NREG];
    logic [NREG-1:0]  busy;
    logic             wr_nz;

    assign wr_nz = we_i && (wa_i != ZERO_ADDR);

    reg_file_sb_scoreboard #(
        .SIZE          (SIZE)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .we_i          (we_i),
        .wa_i          (wa_i),
        .rsv_i         (rsv_i),
        .rsv_addr_i    (rsv_addr_i),
        .rsv_ok_o      (rsv_ok_o),
        .busy_o        (busy),
        .pending_cnt_o (pending_cnt_o)
    );

    // r0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                mem_q[i] <= '0;
        end else if (wr_nz) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [SIZE-1:0] ra;
        assign ra = rd_addr_i[k*SIZE +: SIZE];
`ifdef REG_FILE_SB_BYPASS_EN
        logic byp;
        assign byp = wr_nz && (wa_i == ra);
        assign rd_data_o[k*WIDTH +: WIDTH] = byp ? wd_i : mem_q[ra];
        assign rd_busy_o[k]                = byp ? 1'b0 : busy[ra];
`else
        assign rd_data_o[k*WIDTH +: WIDTH] = mem_q[ra];
        assign rd_busy_o[k]                = busy[ra];
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with default parameters (32x32, two read ports).
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_i;
    logic [4:0]  wa_i;
    logic [31:0] wd_i;
    logic        rsv_i;
    logic [4:0]  rsv_addr_i;
    logic        rsv_ok_o;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_busy_o;
    logic [5:0]  pending_cnt_o;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk           (clk),
        .reset         (reset),
        .we_i          (we_i),
        .wa_i          (wa_i),
        .wd_i          (wd_i),
        .rsv_i         (rsv_i),
        .rsv_addr_i    (rsv_addr_i),
        .rsv_ok_o      (rsv_ok_o),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .rd_busy_o     (rd_busy_o),
        .pending_cnt_o (pending_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i  = 1'b0;
        wa_i  = '0;
        wd_i  = '0;
        rsv_i = 1'b0;
        rsv_addr_i = '0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr_i = {a1, a0};
        #1;
    endtask

    initial begin
        logic any_busy;
        reset = 1'b0;
        idle();
        rd_addr_i = '0;
        tick();

        // Reset state on all ports at 0, 1 and 31.
        rd(5'd0, 5'd1);
        chk("rst_data01", rd_data_o, 64'h0);
        chk("rst_busy01", {62'h0, rd_busy_o}, 64'h0);
        chk("rst_cnt", {58'h0, pending_cnt_o}, 64'h0);
        rd(5'd31, 5'd31);
        chk("rst_data31", rd_data_o, 64'h0);
        chk("rst_busy31", {62'h0, rd_busy_o}, 64'h0);
        tick();
        reset = 1'b1;

        // Reserve r5, re-reserve rejected, then write clears it.
        rsv_i = 1'b1; rsv_addr_i = 5'd5;
        rd(5'd5, 5'd0);
        chk("rsv5_ok", {63'h0, rsv_ok_o}, 64'h1);
        tick();
        chk("rsv5_cnt", {58'h0, pending_cnt_o}, 64'd1);
        rd(5'd5, 5'd0);
        chk("rsv5_again_rej", {63'h0, rsv_ok_o}, 64'h0);
        chk("rsv5_busy", {62'h0, rd_busy_o}, 64'h1);
        tick();
        chk("rsv5_rej_cnt", {58'h0, pending_cnt_o}, 64'd1);
        idle();
        we_i = 1'b1; wa_i = 5'd5; wd_i = 32'hDEADBEEF;
        tick();
        idle();
        rd(5'd5, 5'd0);
        chk("wr5_data", rd_data_o, 64'h0000_0000_DEAD_BEEF);
        chk("wr5_busy", {62'h0, rd_busy_o}, 64'h0);
        chk("wr5_cnt", {58'h0, pending_cnt_o}, 64'd0);

        // Write and re-reserve r7 in the same cycle while r7 is busy.
        rsv_i = 1'b1; rsv_addr_i = 5'd7;
        tick();
        chk("rsv7_cnt", {58'h0, pending_cnt_o}, 64'd1);
        we_i = 1'b1; wa_i = 5'd7; wd_i = 32'h12;
        rd(5'd7, 5'd5);
        chk("wr_rsv7_ok", {63'h0, rsv_ok_o}, 64'h1);
        tick();
        idle();
        rd(5'd7, 5'd5);
        chk("wr_rsv7_data", rd_data_o, 64'hDEAD_BEEF_0000_0012);
        chk("wr_rsv7_busy", {62'h0, rd_busy_o}, 64'h1);
        chk("wr_rsv7_cnt", {58'h0, pending_cnt_o}, 64'd1);
        we_i = 1'b1; wa_i = 5'd7; wd_i = 32'h34;
        tick();
        idle();
        chk("clr7_cnt", {58'h0, pending_cnt_o}, 64'd0);

        // r0 ignores writes and reserves.
        we_i = 1'b1; wa_i = 5'd0; wd_i = 32'hFFFF_FFFF;
        rsv_i = 1'b1; rsv_addr_i = 5'd0;
        rd(5'd0, 5'd0);
        chk("r0_rsv_ok", {63'h0, rsv_ok_o}, 64'h1);
        tick();
        idle();
        rd(5'd0, 5'd7);
        chk("r0_data", rd_data_o, 64'h0000_0034_0000_0000);
        chk("r0_busy", {62'h0, rd_busy_o}, 64'h0);
        chk("r0_cnt", {58'h0, pending_cnt_o}, 64'd0);

        // Write to non-busy r3, reserve it, then write 0xA5 while both ports read r3.
        we_i = 1'b1; wa_i = 5'd3; wd_i = 32'h11;
        tick();
        idle();
        chk("wr3_nonbusy_cnt", {58'h0, pending_cnt_o}, 64'd0);
        rsv_i = 1'b1; rsv_addr_i = 5'd3;
        tick();
        idle();
        we_i = 1'b1; wa_i = 5'd3; wd_i = 32'hA5;
        rd(5'd3, 5'd3);
`ifdef REG_FILE_SB_BYPASS_EN
        chk("byp3_data", rd_data_o, 64'h0000_00A5_0000_00A5);
        chk("byp3_busy", {62'h0, rd_busy_o}, 64'h0);
`else
        chk("nobyp3_data", rd_data_o, 64'h0000_0011_0000_0011);
        chk("nobyp3_busy", {62'h0, rd_busy_o}, 64'h3);
`endif
        tick();
        idle();
        rd(5'd3, 5'd5);
        chk("wr3_data", rd_data_o, 64'hDEAD_BEEF_0000_00A5);
        chk("wr3_cnt", {58'h0, pending_cnt_o}, 64'd0);

        // Reserve + write of a non-busy register counts +1; reserve + clear elsewhere nets zero.
        we_i = 1'b1; wa_i = 5'd9; wd_i = 32'h99;
        rsv_i = 1'b1; rsv_addr_i = 5'd9;
        tick();
        idle();
        rd(5'd9, 5'd11);
        chk("wr_rsv9_data", rd_data_o[31:0], 64'h99);
        chk("wr_rsv9_busy", {62'h0, rd_busy_o}, 64'h1);
        chk("wr_rsv9_cnt", {58'h0, pending_cnt_o}, 64'd1);
        we_i = 1'b1; wa_i = 5'd9; wd_i = 32'h98;
        rsv_i = 1'b1; rsv_addr_i = 5'd11;
        tick();
        idle();
        rd(5'd9, 5'd11);
        chk("swap_busy", {62'h0, rd_busy_o}, 64'h2);
        chk("swap_cnt", {58'h0, pending_cnt_o}, 64'd1);
        we_i = 1'b1; wa_i = 5'd11; wd_i = 32'h0;
        tick();
        idle();

        // Reserve r1..r20, then reset mid-sequence.
        for (int i = 1; i <= 20; i++) begin
            rsv_i = 1'b1; rsv_addr_i = 5'(i);
            tick();
        end
        idle();
        chk("seq20_cnt", {58'h0, pending_cnt_o}, 64'd20);
        reset = 1'b0;
        rd(5'd5, 5'd1);
        chk("midrst_cnt", {58'h0, pending_cnt_o}, 64'd0);
        chk("midrst_data", rd_data_o, 64'h0);
        any_busy = 1'b0;
        for (int a = 0; a < 32; a += 2) begin
            rd(5'(a), 5'(a + 1));
            any_busy = any_busy | (|rd_busy_o);
        end
        chk("midrst_allbusy", {63'h0, any_busy}, 64'h0);
        tick();
        reset = 1'b1;

        // Full reserve of r1..r31 from the first edge after reset: count saturates at 31.
        for (int i = 1; i <= 31; i++) begin
            rsv_i = 1'b1; rsv_addr_i = 5'(i);
            tick();
        end
        chk("full_cnt", {58'h0, pending_cnt_o}, 64'd31);
        rsv_addr_i = 5'd31;
        #1;
        chk("full_rej", {63'h0, rsv_ok_o}, 64'h0);
        tick();
        idle();
        rd(5'd1, 5'd31);
        chk("full_cnt_hold", {58'h0, pending_cnt_o}, 64'd31);
        chk("full_busy", {62'h0, rd_busy_o}, 64'h3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
